// File: rtl/pc_pkg.sv
// Shared op-code encodings and default vectors for the program-counter sequencer.
package pc_pkg;
  localparam logic [2:0] PC_OP_HOLD     = 3'd0;
  localparam logic [2:0] PC_OP_INC      = 3'd1;
  localparam logic [2:0] PC_OP_DEC      = 3'd2;
  localparam logic [2:0] PC_OP_LOAD_BUS = 3'd3;
  localparam logic [2:0] PC_OP_LOAD_MDR = 3'd4;
  localparam logic [2:0] PC_OP_REL      = 3'd5;
  localparam logic [2:0] PC_OP_CALL     = 3'd6;
  localparam logic [2:0] PC_OP_RET      = 3'd7;

  localparam logic [15:0] PC_RST_VEC_DEF  = 16'h0000;
  localparam logic [15:0] PC_TRAP_VEC_DEF = 16'h0010;
endpackage

// File: rtl/pc_seq_if.sv
// Control-unit / fetch-path view of the PC sequencer: commands in, PC and stack status out.
interface pc_seq_if #(
  parameter int W     = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic          en;
  logic [2:0]    op;
  logic [W-1:0]  bus_in;
  logic [W-1:0]  mdr_in;
  logic [W-1:0]  offset;
  logic          int_req;
  logic [W-1:0]  int_vec;
  logic          err_clr;
  logic          int_ack;
  logic [W-1:0]  pc;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic          err;

  modport master (
    output en, op, bus_in, mdr_in, offset, int_req, int_vec, err_clr,
    input  int_ack, pc, depth, full, empty, err
  );

  modport slave (
    input  en, op, bus_in, mdr_in, offset, int_req, int_vec, err_clr,
    output int_ack, pc, depth, full, empty, err
  );
endinterface

// File: rtl/pc_stack.sv
// Return-address LIFO: push/pop with overflow/underflow detect; faulting requests leave state untouched.
// Latency: depth/flags update on the edge after the request; top-of-stack read is combinational.
// Backpressure: none; full/empty are reported and misuse is flagged via ovf/unf.
module pc_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     unf
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] cnt;

  assign depth = cnt;
  assign full  = (cnt == DW'(DEPTH));
  assign empty = (cnt == '0);
  assign ovf   = push & full;
  assign unf   = pop & empty;
  assign dout  = mem[cnt[AW-1:0] - AW'(1)];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (push && !full)
      cnt <= cnt + DW'(1);
    else if (pop && !empty)
      cnt <= cnt - DW'(1);
  end

  // Entries survive reset; depth=0 is what makes them unreachable.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[cnt[AW-1:0]] <= din;
  end
endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with hardware return stack; optional PC_STACK_TRAP_EN vectors stack faults to TRAP_VEC.
// Latency: one cycle, all outputs registered. Backpressure: en=0 stalls and holds all state.
module pc_seq
  import pc_pkg::*;
#(
  parameter int             W        = 16,
  parameter int             DEPTH    = 8,
  parameter logic [W-1:0]   RST_VEC  = W'(PC_RST_VEC_DEF),
  parameter logic [W-1:0]   TRAP_VEC = W'(PC_TRAP_VEC_DEF)
) (
  input  logic      clk,
  input  logic      rst,
  pc_seq_if.slave   bus
);
  logic [W-1:0] pc_q, pc_nxt, push_dat, stk_top;
  logic         push, pop, ovf, unf, fault;
  logic         int_ack_q, err_q;
  logic         stk_full, stk_empty;
  logic [$clog2(DEPTH):0] stk_depth;

  pc_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_dat),
    .dout  (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty),
    .ovf   (ovf),
    .unf   (unf)
  );

  // Interrupt outranks op; an accepted interrupt saves the PC of the instruction to resume.
  always_comb begin
    pc_nxt   = pc_q;
    push     = 1'b0;
    pop      = 1'b0;
    push_dat = pc_q + W'(1);
    if (bus.en) begin
      if (bus.int_req) begin
        push     = 1'b1;
        push_dat = pc_q;
        pc_nxt   = bus.int_vec;
      end else begin
        case (bus.op)
          PC_OP_INC:      pc_nxt = pc_q + W'(1);
          PC_OP_DEC:      pc_nxt = pc_q - W'(1);
          PC_OP_LOAD_BUS: pc_nxt = bus.bus_in;
          PC_OP_LOAD_MDR: pc_nxt = bus.mdr_in;
          PC_OP_REL:      pc_nxt = pc_q + bus.offset;
          PC_OP_CALL: begin
            push   = 1'b1;
            pc_nxt = bus.bus_in;
          end
          PC_OP_RET: begin
            pop    = 1'b1;
            pc_nxt = stk_empty ? pc_q : stk_top;
          end
          default:        pc_nxt = pc_q;
        endcase
      end
    end
    fault = ovf | unf;
`ifdef PC_STACK_TRAP_EN
    if (fault)
      pc_nxt = TRAP_VEC;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RST_VEC;
      int_ack_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_nxt;
      int_ack_q <= bus.en & bus.int_req;
      if (fault)
        err_q <= 1'b1;
      else if (bus.en && bus.err_clr)
        err_q <= 1'b0;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.int_ack = int_ack_q;
  assign bus.err     = err_q;
  assign bus.depth   = stk_depth;
  assign bus.full    = stk_full;
  assign bus.empty   = stk_empty;
endmodule

// File: tb/tb_pc_seq.sv
// Scoreboarded bench for pc_seq (W=16, DEPTH=2, RST_VEC=0x0100); honours PC_STACK_TRAP_EN.
module tb_pc_seq;
  import pc_pkg::*;

  localparam int           W        = 16;
  localparam int           DEPTH    = 2;
  localparam logic [15:0]  RST_VEC  = 16'h0100;
  localparam logic [15:0]  TRAP_VEC = 16'h0010;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    int          depth;
    logic        err;
    logic        ack;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  exp_t        sb_q[$];
  logic [15:0] m_stk[$];
  logic [15:0] m_pc;
  logic        m_err;
  logic        m_ack;

  pc_seq_if #(.W(W), .DEPTH(DEPTH)) ifc ();

  pc_seq #(.W(W), .DEPTH(DEPTH), .RST_VEC(RST_VEC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk({e.tag, ".pc"},    32'(ifc.pc),      32'(e.pc));
    chk({e.tag, ".depth"}, 32'(ifc.depth),   32'(e.depth));
    chk({e.tag, ".full"},  32'(ifc.full),    32'(e.depth == DEPTH));
    chk({e.tag, ".empty"}, 32'(ifc.empty),   32'(e.depth == 0));
    chk({e.tag, ".err"},   32'(ifc.err),     32'(e.err));
    chk({e.tag, ".ack"},   32'(ifc.int_ack), 32'(e.ack));
  endtask

  task automatic model_reset();
    m_pc  = RST_VEC;
    m_err = 1'b0;
    m_ack = 1'b0;
    m_stk.delete();
  endtask

  // Drive one cycle of stimulus, predict the result, then compare after the edge.
  task automatic step(input string tag, input logic en, input logic [2:0] op,
                      input logic [15:0] bus_v, input logic [15:0] mdr_v,
                      input logic [15:0] off_v, input logic ireq,
                      input logic [15:0] ivec, input logic clr);
    logic [15:0] npc;
    logic        flt;
    exp_t        e;
    exp_t        got;
    @(negedge clk);
    ifc.en = en;  ifc.op = op;  ifc.bus_in = bus_v;  ifc.mdr_in = mdr_v;
    ifc.offset = off_v;  ifc.int_req = ireq;  ifc.int_vec = ivec;  ifc.err_clr = clr;
    npc = m_pc;
    flt = 1'b0;
    if (en) begin
      if (ireq) begin
        if (m_stk.size() == DEPTH) flt = 1'b1; else m_stk.push_back(m_pc);
        npc = ivec;
      end else begin
        case (op)
          PC_OP_INC:      npc = m_pc + 16'd1;
          PC_OP_DEC:      npc = m_pc - 16'd1;
          PC_OP_LOAD_BUS: npc = bus_v;
          PC_OP_LOAD_MDR: npc = mdr_v;
          PC_OP_REL:      npc = m_pc + off_v;
          PC_OP_CALL: begin
            if (m_stk.size() == DEPTH) flt = 1'b1; else m_stk.push_back(m_pc + 16'd1);
            npc = bus_v;
          end
          PC_OP_RET: begin
            if (m_stk.size() == 0) flt = 1'b1; else npc = m_stk.pop_back();
          end
          default: npc = m_pc;
        endcase
      end
`ifdef PC_STACK_TRAP_EN
      if (flt) npc = TRAP_VEC;
`endif
      if (flt) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
    m_pc  = npc;
    m_ack = en & ireq;
    e.tag = tag;  e.pc = m_pc;  e.depth = m_stk.size();  e.err = m_err;  e.ack = m_ack;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check_outputs(got);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ifc.en = 0; ifc.op = PC_OP_HOLD; ifc.bus_in = 0; ifc.mdr_in = 0;
    ifc.offset = 0; ifc.int_req = 0; ifc.int_vec = 0; ifc.err_clr = 0;
    rst = 1'b0;
    model_reset();
    #12;
    chk("rst.pc",    32'(ifc.pc), 32'h0100);
    chk("rst.empty", 32'(ifc.empty), 32'd1);
    chk("rst.full",  32'(ifc.full), 32'd0);
    chk("rst.err",   32'(ifc.err), 32'd0);
    chk("rst.ack",   32'(ifc.int_ack), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    repeat (3) step("inc", 1, PC_OP_INC, 0, 0, 0, 0, 0, 0);
    chk("inc3.pc", 32'(ifc.pc), 32'h0103);

    // Asynchronous reset asserted between edges takes effect at once.
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst.pc",    32'(ifc.pc), 32'h0100);
    chk("arst.depth", 32'(ifc.depth), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    step("ld_ffff", 1, PC_OP_LOAD_BUS, 16'hFFFF, 0, 0, 0, 0, 0);
    step("wrap_inc", 1, PC_OP_INC, 0, 0, 0, 0, 0, 0);
    chk("wrap_inc.const", 32'(ifc.pc), 32'h0000);
    step("rel_neg", 1, PC_OP_REL, 0, 0, 16'hFFFE, 0, 0, 0);
    chk("rel_neg.const", 32'(ifc.pc), 32'hFFFE);
    step("dec", 1, PC_OP_DEC, 0, 0, 0, 0, 0, 0);
    chk("dec.const", 32'(ifc.pc), 32'hFFFD);

    step("ld_mdr", 1, PC_OP_LOAD_MDR, 0, 16'h0200, 0, 0, 0, 0);
    step("call", 1, PC_OP_CALL, 16'h0400, 0, 0, 0, 0, 0);
    chk("call.const", 32'(ifc.pc), 32'h0400);
    step("ret", 1, PC_OP_RET, 0, 0, 0, 0, 0, 0);
    chk("ret.const", 32'(ifc.pc), 32'h0201);

    step("ld_300", 1, PC_OP_LOAD_BUS, 16'h0300, 0, 0, 0, 0, 0);
    step("irq", 1, PC_OP_LOAD_BUS, 16'h0500, 0, 0, 1, 16'h0040, 0);
    chk("irq.const", 32'(ifc.pc), 32'h0040);
    step("irq_ret", 1, PC_OP_RET, 0, 0, 0, 0, 0, 0);
    chk("irq_ret.const", 32'(ifc.pc), 32'h0300);

    step("b2b_call", 1, PC_OP_CALL, 16'h0800, 0, 0, 0, 0, 0);
    step("b2b_ret",  1, PC_OP_RET, 0, 0, 0, 0, 0, 0);
    step("b2b_call2", 1, PC_OP_CALL, 16'h0900, 0, 0, 0, 0, 0);
    step("b2b_ret2", 1, PC_OP_RET, 0, 0, 0, 0, 0, 0);

    step("ovf_c1", 1, PC_OP_CALL, 16'h1000, 0, 0, 0, 0, 0);
    step("ovf_c2", 1, PC_OP_CALL, 16'h2000, 0, 0, 0, 0, 0);
    step("ovf_c3", 1, PC_OP_CALL, 16'h3000, 0, 0, 0, 0, 0);
`ifdef PC_STACK_TRAP_EN
    chk("ovf.pc_const", 32'(ifc.pc), 32'(TRAP_VEC));
`else
    chk("ovf.pc_const", 32'(ifc.pc), 32'h3000);
`endif
    step("clr1", 1, PC_OP_HOLD, 0, 0, 0, 0, 0, 1);
    step("irq_ovf", 1, PC_OP_INC, 0, 0, 0, 1, 16'h0044, 1);
    step("irq_ovf_ack", 1, PC_OP_HOLD, 0, 0, 0, 0, 0, 0);
    step("clr2", 1, PC_OP_HOLD, 0, 0, 0, 0, 0, 1);
    step("pop1", 1, PC_OP_RET, 0, 0, 0, 0, 0, 0);
    step("pop2", 1, PC_OP_RET, 0, 0, 0, 0, 0, 0);
    step("unf", 1, PC_OP_RET, 0, 0, 0, 0, 0, 0);
    step("clr3", 1, PC_OP_HOLD, 0, 0, 0, 0, 0, 1);
    step("stall", 0, PC_OP_INC, 0, 0, 0, 1, 16'h0077, 0);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(7) != 0), 3'($urandom_range(7)),
           16'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(7) == 0), 16'($urandom), ($urandom_range(5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer; successor to the fixed 16-bit PC register. Holds the fetch address and updates it once per enabled cycle from an encoded operation: increment, decrement, absolute load from the bus or the MDR, PC-relative branch, call and return. Contains a hardware return-address stack that interrupts and calls use, so nested handlers return without software save. Sits between the control unit (which drives `op`/`en`) and the fetch path (which consumes `pc`).

## Interface
- `W`, 16: PC and data width in bits.
- `DEPTH`, 8: return-stack entries; a power of two, at least 2.
- `RST_VEC`, 0: PC value loaded on reset.
- `TRAP_VEC`, 16'h0010: PC loaded on a stack fault when `PC_STACK_TRAP_EN` is defined.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance enable; 0 = stall, all state held, `int_req` ignored.
- `op`  in  3  operation code (see Operation).
- `bus_in`  in  W  absolute target for LOAD_BUS and CALL.
- `mdr_in`  in  W  absolute target for LOAD_MDR.
- `offset`  in  W  two's-complement displacement for REL.
- `int_req`  in  1  interrupt request, level.
- `int_vec`  in  W  handler address.
- `int_ack`  out  1  one-cycle pulse; interrupt taken.
- `pc`  out  W  current program counter.
- `depth`  out  $clog2(DEPTH)+1  occupied stack entries.
- `full`, `empty`  out  1  `depth == DEPTH` and `depth == 0`.
- `err`  out  1  sticky stack fault.
- `err_clr`  in  1  clears `err`.

## Operation
- Op codes: 0 HOLD, 1 INC (pc+1), 2 DEC (pc-1), 3 LOAD_BUS, 4 LOAD_MDR, 5 REL (pc+offset), 6 CALL (push pc+1, pc<=bus_in), 7 RET (pop into pc).
- All arithmetic is modulo 2^W. 0xFFFF+1 gives 0, and 0-1 gives 0xFFFF, with no flag.
- Priority per enabled cycle: reset, then interrupt (`int_req`=1), then `op`. An accepted interrupt pushes the current `pc` (the instruction to resume) and loads `int_vec`. The `op` in that cycle is discarded.
- The stack is a LIFO with a top pointer. A push writes `stack[depth]` and increments `depth`. A pop reads `stack[depth-1]` and decrements `depth`.
- A push (CALL or interrupt) while `full` is an overflow. A RET while `empty` is an underflow. On either fault, the stack and `depth` are unchanged and `err` is set to 1.
- Without the trap macro:
  - overflow CALL or interrupt still loads its target; the return address is lost;
  - underflow RET holds `pc`.
- `err_clr` clears `err` unless a fault occurs in the same cycle; the fault wins.
- `int_ack` is asserted for exactly the cycle after acceptance, even on overflow.

## Timing
- Reset (`rst`=0, asynchronous) gives:
  - `pc`=RST_VEC, `depth`=0, `empty`=1, `full`=0;
  - `err`=0, `int_ack`=0.
- Release is synchronous to `clk`. The first update happens on the first rising edge with `rst`=1 and `en`=1.
- One-cycle latency: `pc`, `depth`, `full`, `empty` and `err` reflect the operation on the edge after it is presented. All outputs are registered.
- A reset asserted mid-call or mid-interrupt discards stack contents. Entries are not cleared, but `depth`=0 makes them unreachable.
- Back-to-back CALL/RET, RET/CALL and interrupt/RET sequences run at full rate, with no bubbles.
- A `int_req` held high is taken again on the next enabled cycle. The control unit must drop it after `int_ack`.

## Configuration
- `PC_STACK_TRAP_EN` defined: any stack fault also loads `pc`<=TRAP_VEC. This overrides the op's or the interrupt's target, and `int_ack` still pulses.
- Not defined: fault behaviour is as in Operation, and TRAP_VEC is unused.

## Structure
- Shared package `pc_pkg` holds:
  - the 3-bit op-code constants (`PC_OP_HOLD` … `PC_OP_RET`);
  - the default RST_VEC and TRAP_VEC.
- Sub-module `pc_stack`:
  - parametrised W/DEPTH LIFO with push/pop/full/empty/depth and fault detect;
  - the top level holds the PC register, the priority mux and the `int_ack`/`err` flops.

## Test plan
- Reset with W=16, RST_VEC=0x0100, then INC×3 → `pc`=0x0103. Assert `rst`=0 mid-cycle → `pc`=0x0100 immediately.
- `pc`=0xFFFF, INC → 0x0000. Then REL with offset=0xFFFE → 0xFFFE. Then DEC → 0xFFFD.
- At `pc`=0x0200, CALL with bus_in=0x0400 → `pc`=0x0400, `depth`=1. RET → `pc`=0x0201, `empty`=1.
- At `pc`=0x0300, `int_req` together with op=LOAD_BUS(0x0500) → `pc`=int_vec=0x0040, `int_ack`=1 for 1 cycle, stack top=0x0300. RET → `pc`=0x0300.
- DEPTH=2: three CALLs → third sets `err`=1, `depth`=2. Trap build: `pc`=TRAP_VEC. Non-trap build: `pc`=bus_in.
- RET on empty → `err`=1. Non-trap build: `pc` unchanged. `err_clr` → `err`=0; `en`=0 with op=INC → `pc` held.
